// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into CHUNK-bit slices, one slice per
// pipeline stage, with the inter-slice carry registered between stages.
// A valid/ready handshake with a global stall gives backpressure support.
// Throughput is one operation per cycle and latency is STAGES cycles.
// Optional feature macro: PIPELINED_ADDER_SUB_EN adds a 'sub' input that
// turns the operation into A-B (B inverted, carry-in forced to 1).
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // The whole pipeline moves together; a result held at the output freezes it.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Effective B operand and carry into bit 0.
  logic [WIDTH-1:0] b_eff;
  logic             carry0;
`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff  = sub ? ~b : b;
  assign carry0 = sub ? 1'b1 : cin;
`else
  assign b_eff  = b;
  assign carry0 = cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Bits of the operands still to be added after this stage.
    localparam int REST_W = WIDTH - (k + 1) * CHUNK;

    logic [CHUNK-1:0]         a_slice;
    logic [CHUNK-1:0]         b_slice;
    logic                     c_in;
    logic                     v_in;
    logic                     a_msb_in;
    logic                     b_msb_in;
    logic [CHUNK:0]           part;
    logic [(k+1)*CHUNK-1:0]   s_next;

    logic                     v_q;
    logic                     c_q;
    logic                     a_msb_q;
    logic                     b_msb_q;
    logic [(k+1)*CHUNK-1:0]   s_q;

    if (k == 0) begin : g_first
      assign a_slice  = a[CHUNK-1:0];
      assign b_slice  = b_eff[CHUNK-1:0];
      assign c_in     = carry0;
      assign v_in     = in_valid && in_ready;
      assign a_msb_in = a[WIDTH-1];
      assign b_msb_in = b_eff[WIDTH-1];
      assign s_next   = part[CHUNK-1:0];
    end else begin : g_next
      assign a_slice  = g_stage[k-1].g_rest.a_rest[CHUNK-1:0];
      assign b_slice  = g_stage[k-1].g_rest.b_rest[CHUNK-1:0];
      assign c_in     = g_stage[k-1].c_q;
      assign v_in     = g_stage[k-1].v_q;
      assign a_msb_in = g_stage[k-1].a_msb_q;
      assign b_msb_in = g_stage[k-1].b_msb_q;
      assign s_next   = {part[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign part = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, c_in};

    // Stage register: valid bit, carry, aligned sum slices and sign bits.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking (<=) so each stage samples its neighbour's pre-edge value.
      if (rst) begin
        v_q     <= 1'b0;
        c_q     <= 1'b0;
        a_msb_q <= 1'b0;
        b_msb_q <= 1'b0;
        s_q     <= '0;
      end else if (advance) begin
        v_q     <= v_in;
        c_q     <= part[CHUNK];
        a_msb_q <= a_msb_in;
        b_msb_q <= b_msb_in;
        s_q     <= s_next;
      end
    end

    if (REST_W > 0) begin : g_rest
      logic [REST_W-1:0] a_rest;
      logic [REST_W-1:0] b_rest;
      logic [REST_W-1:0] a_rest_in;
      logic [REST_W-1:0] b_rest_in;

      if (k == 0) begin : g_src_in
        assign a_rest_in = a[WIDTH-1:CHUNK];
        assign b_rest_in = b_eff[WIDTH-1:CHUNK];
      end else begin : g_src_prev
        assign a_rest_in = g_stage[k-1].g_rest.a_rest[REST_W+CHUNK-1:CHUNK];
        assign b_rest_in = g_stage[k-1].g_rest.b_rest[REST_W+CHUNK-1:CHUNK];
      end

      // Delay line for the operand slices not yet consumed.
      always_ff @(posedge clk) begin
        // NOTE: operand delay lines carry no reset; their contents are ignored while the matching valid bit is low.
        if (advance) begin
          a_rest <= a_rest_in;
          b_rest <= b_rest_in;
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].s_q;
  assign cout      = g_stage[LAST].c_q;
  assign overflow  = (g_stage[LAST].a_msb_q == g_stage[LAST].b_msb_q) &&
                     (g_stage[LAST].s_q[WIDTH-1] != g_stage[LAST].a_msb_q);

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder: directed vector table with latency checks,
// stream / backpressure / mid-stream reset sequences, and randomized traffic
// scored against an arithmetic reference model.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
`ifdef PIPELINED_ADDER_SUB_EN
  logic             sub;
`endif

  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic s);
    res_t r;
    logic [WIDTH-1:0] y_eff;
    logic             c0;
    logic [WIDTH:0]   full;
    longint           sres;
    longint           smax;
    longint           smin;
    y_eff = s ? ~y : y;
    c0    = s ? 1'b1 : c;
    full  = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, c0};
    sres  = longint'($signed(x)) + longint'($signed(y_eff)) + longint'(c0);
    smax  = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin  = -(longint'(1) <<< (WIDTH - 1));
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (sres > smax) || (sres < smin);
    return r;
  endfunction

  // ---------------- scoreboard-driven cycle ----------------
  res_t exp_q[$];
  int   cyc = 0;
  int   cons_cycles[$];
  logic hold_pending = 1'b0;
  res_t held;

  task automatic drive(input logic iv, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic ordy, input logic s);
    in_valid  = iv;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = ordy;
`ifdef PIPELINED_ADDER_SUB_EN
    sub       = s;
`endif
  endtask

  task automatic cycle(input logic iv, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic ordy, input logic s, output logic accepted);
    res_t e;
    drive(iv, x, y, c, ordy, s);
    #1;
    if (hold_pending) begin
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, held.sum);
      check("hold_cout", cout, held.cout);
      check("hold_ovf", overflow, held.ovf);
    end
    if (out_valid && !ordy) check("stall_in_ready", in_ready, 0);
    if (!out_valid) check("idle_in_ready", in_ready, 1);
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_sum", sum, e.sum);
        check("sb_cout", cout, e.cout);
        check("sb_ovf", overflow, e.ovf);
        cons_cycles.push_back(cyc);
      end
    end
    hold_pending = out_valid && !ordy;
    held.sum  = sum;
    held.cout = cout;
    held.ovf  = overflow;
    accepted = iv && in_ready;
    if (accepted) exp_q.push_back(model(x, y, c, s));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    hold_pending = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  task automatic directed(input string name, input vec_t v);
    int n;
    drive(1'b1, v.a, v.b, v.cin, 1'b1, v.sub);
    #1;
    check($sformatf("%s_in_ready", name), in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s_latency", name), n, STAGES - 1);
    check($sformatf("%s_sum", name), sum, v.sum);
    check($sformatf("%s_cout", name), cout, v.cout);
    check($sformatf("%s_ovf", name), overflow, v.ovf);
    @(posedge clk);
    #1;
    check($sformatf("%s_drained", name), out_valid, 0);
  endtask

  initial begin
    vec_t vecs[$];
    logic acc;
    int   i;
    int   t;
    int   base;

    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0});
    vecs.push_back('{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0});
`ifdef PIPELINED_ADDER_SUB_EN
    vecs.push_back('{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
`endif

    // Reset state
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", overflow, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed table with latency measurement
    foreach (vecs[k]) directed($sformatf("vec%0d", k), vecs[k]);

    // Back-to-back stream: 8 in-order results on consecutive cycles
    cons_cycles.delete();
    for (int k = 0; k < 8; k++)
      cycle(1'b1, WIDTH'(k), WIDTH'(k) * 32'h0101_0101, k[0], 1'b1, 1'b0, acc);
    idle(STAGES + 4);
    check("stream_count", cons_cycles.size(), 8);
    if (cons_cycles.size() == 8) check("stream_no_gaps", cons_cycles[7] - cons_cycles[0], 7);

    // Backpressure: out_ready low for 5 cycles mid-stream
    base = cons_cycles.size();
    i = 0;
    t = 0;
    while (i < 12 && t < 60) begin
      cycle(1'b1, 32'h0100_0000 * WIDTH'(i) + 32'h00FF_FFF0, 32'h0000_0011 * WIDTH'(i), i[0],
            !(t >= 4 && t < 9), 1'b0, acc);
      if (acc) i++;
      t++;
    end
    check("bp_all_accepted", i, 12);
    idle(STAGES + 4);
    check("bp_delivered", cons_cycles.size() - base, 12);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset with 3 operations in flight
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'hAAAA_0000 + WIDTH'(k), 32'h5555_0000, 1'b0, 1'b1, 1'b0, acc);
    do_reset();
    check("midrst_out_valid", out_valid, 0);
    base = cons_cycles.size();
    idle(STAGES + 3);
    check("midrst_no_stale", cons_cycles.size() - base, 0);
    directed("post_rst", '{32'd5, 32'd7, 1'b0, 1'b0, 32'd12, 1'b0, 1'b0});

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      logic s;
`ifdef PIPELINED_ADDER_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      cycle(($urandom_range(0, 9) < 7), $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7), s, acc);
    end
    idle(STAGES + 4);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the fixed-width chained ripple adders.
- Splits a WIDTH-bit add into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Uses a valid/ready handshake, so it drops into datapaths that need wide adds at high clock rates with backpressure.
- Throughput is one operation per cycle; latency is STAGES cycles.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per stage.
- STAGES, WIDTH/CHUNK (localparam, derived), pipeline depth and latency in cycles.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b/cin are valid this cycle.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout/overflow are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  A+B+cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement signed overflow.

Interface decision: one clock (clk); reset (rst) is synchronous and active-high.

Behaviour:
- Reset: all stage valid bits are cleared. out_valid=0, sum=0, cout=0, overflow=0. in_ready=1 in the cycle after rst deasserts. A reset mid-operation discards all in-flight operations; no partial result is ever presented.
- Advance: advance = !out_valid || out_ready. The whole pipeline moves together when advance=1 and holds every register when advance=0 (global stall). in_ready = advance, combinational.
- Transfer: an input is accepted on in_valid && in_ready; a result is consumed on out_valid && out_ready.
- Stage k (0..STAGES-1):
  - Adds a[k*CHUNK +: CHUNK] + b[k*CHUNK +: CHUNK] + carry_k, with carry_0 = cin.
  - Registers the CHUNK-bit partial sum and carry_{k+1}.
  - Unconsumed upper operand slices travel through delay registers alongside.
  - Completed lower sum slices are delayed so all slices align at the output.
- Valid tracking: stage k's valid bit takes stage k-1's valid bit on advance. Stage 0 takes in_valid && in_ready.
- Latency: a result accepted at edge T is presented at out_valid after edge T+STAGES-1, i.e. out_valid is high during cycle T+STAGES−1.
- Outputs:
  - cout = carry_STAGES.
  - overflow = (a[W-1]==b'[W-1]) && (sum[W-1]!=a[W-1]), where b' is the effective B operand. a[W-1] and b'[W-1] are carried down the pipeline.
- Bubbles: a bubble (in_valid=0 while advancing) propagates as valid=0. Data registers may load don't-care values when valid=0.
- Hold: while out_valid && !out_ready, sum/cout/overflow stay stable and no input is accepted.
- Simultaneous events: accept-in and deliver-out in the same cycle are allowed, sustaining 1 op/cycle.
- STAGES==1 (CHUNK==WIDTH): degenerates to a single registered adder with the same handshake.
- Elaboration: an elaboration-time check fails if WIDTH % CHUNK != 0.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- Defined: adds port sub (input, 1), sampled with a/b. When sub=1, b' = ~b and carry_0 = 1 (cin is ignored), producing A−B. cout then means "no borrow", and overflow uses b'. sub travels with its operation.
- Undefined: no sub port; b' = b and carry_0 = cin.

Test Plan:
- Defaults (WIDTH=32, CHUNK=8): a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> out_valid exactly 4 cycles after acceptance; sum=0x00000000, cout=1, overflow=0.
- a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, overflow=1. Then a=0x80000000, b=0x80000000 -> sum=0, cout=1, overflow=1.
- Stream of 8 back-to-back ops (a=i, b=i*0x01010101, cin=i&1) with out_ready=1 -> 8 consecutive in-order results, one per cycle, no gaps.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid=1, outputs stable; no results lost or duplicated after release.
- Reset mid-stream: assert rst with 3 ops in flight -> out_valid=0 next cycle; no stale result appears afterwards; a new op a=5, b=7 yields sum=12.
- PIPELINED_ADDER_SUB_EN: a=3, b=5, sub=1 -> sum=0xFFFFFFFE, cout=0. a=5, b=3, sub=1 -> sum=2, cout=1.
